door_ctrl: RTL and testbench

Elevator door sequencer: the consumer of the seconds count produced by the free-running seconds timer. It derives one-second ticks from changes on that count. It sequences the door through opening, open-dwell, and closing phases, using a request from the car controller and passenger buttons. When the door is fully shut, it returns a one-cycle completion pulse to the car controller.

---
 rtl/door_ctrl_if.sv | 24 ++
 rtl/door_ctrl.sv | 131 +++++++++++++
 tb/tb_door_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/door_ctrl_if.sv
// Door sequencer bus: car-controller requests, passenger buttons and door status.
// The car controller side is the master; door_ctrl is the slave.
interface door_ctrl_if;
    logic [3:0] sec_in;
    logic       arrive;
    logic       hold_btn;
    logic       close_btn;
    logic       obstruct;
    logic       door_open;
    logic [1:0] motor;
    logic       busy;
    logic       done;
    logic [1:0] state;

    modport master (
        output sec_in, arrive, hold_btn, close_btn, obstruct,
        input  door_open, motor, busy, done, state
    );

    modport slave (
        input  sec_in, arrive, hold_btn, close_btn, obstruct,
        output door_open, motor, busy, done, state
    );
endinterface

// File: rtl/door_ctrl.sv
// Elevator door sequencer: turns seconds-count changes into ticks and steps the door
// through opening, open dwell and closing, pulsing done when the door is shut.
module door_ctrl #(
    parameter int unsigned MOVE_SEC = 2,
    parameter int unsigned OPEN_SEC = 3,
    parameter int unsigned HOLD_MAX = 9
) (
    input logic        clk,
    input logic        reseta,
    door_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        StClosed  = 2'd0,
        StOpening = 2'd1,
        StOpen    = 2'd2,
        StClosing = 2'd3
    } state_e;

    localparam logic [4:0] MoveLim = 5'(MOVE_SEC);
    localparam logic [4:0] OpenLim = 5'(OPEN_SEC);
    localparam logic [4:0] HoldLim = 5'(HOLD_MAX);
    localparam logic [3:0] Move4   = 4'(MOVE_SEC);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] tot_q, tot_d;
    logic [3:0] sec_prev_q;
    logic       primed_q;
    logic       done_q, done_d;
    logic       tick;

    logic [4:0] cnt_nx, tot_nx;
    logic [3:0] cnt_inc, tot_inc;
    logic [3:0] rev_raw, rev_cnt;

    assign tick    = primed_q & (bus.sec_in != sec_prev_q);
    assign cnt_nx  = {1'b0, cnt_q} + 5'd1;
    assign tot_nx  = {1'b0, tot_q} + 5'd1;
    assign cnt_inc = (cnt_q == 4'hf) ? 4'hf : cnt_q + 4'd1;
    assign tot_inc = (tot_q == 4'hf) ? 4'hf : tot_q + 4'd1;

    // Reopen retraces the distance already closed, but always takes at least one tick.
    assign rev_raw = Move4 - cnt_q;
    assign rev_cnt = (rev_raw > Move4 - 4'd1) ? Move4 - 4'd1 : rev_raw;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tot_d   = tot_q;
        done_d  = 1'b0;
        unique case (state_q)
            StClosed: begin
                if (bus.arrive) begin
                    state_d = StOpening;
                    cnt_d   = '0;
                end
            end
            StOpening: begin
                if (tick) begin
                    if (cnt_nx == MoveLim) begin
                        state_d = StOpen;
                        cnt_d   = '0;
                        tot_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            StOpen: begin
                if (tick && tot_nx == HoldLim) begin
                    state_d = StClosing;
                    cnt_d   = '0;
                end else if (bus.hold_btn) begin
                    cnt_d = '0;
                    if (tick) tot_d = tot_inc;
                end else if (bus.close_btn) begin
                    state_d = StClosing;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_nx == OpenLim) begin
                        state_d = StClosing;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        tot_d = tot_inc;
                    end
                end
            end
            StClosing: begin
                if (bus.obstruct) begin
                    state_d = StOpening;
                    cnt_d   = rev_cnt;
                end else if (tick) begin
                    if (cnt_nx == MoveLim) begin
                        state_d = StClosed;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reseta) begin
        if (!reseta) begin
            state_q    <= StClosed;
            cnt_q      <= '0;
            tot_q      <= '0;
            sec_prev_q <= '0;
            primed_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tot_q      <= tot_d;
            sec_prev_q <= bus.sec_in;
            primed_q   <= 1'b1;
            done_q     <= done_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.door_open = (state_q == StOpen);
    assign bus.motor     = (state_q == StOpening) ? 2'b01 :
                           (state_q == StClosing) ? 2'b10 : 2'b00;
    assign bus.busy      = (state_q != StClosed);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_door_ctrl.sv
// Bench for door_ctrl: directed door scenarios followed by random traffic, all
// checked every cycle against a remaining-ticks model of the door.
module tb_door_ctrl;
    localparam int MOVE = 2;
    localparam int OPN  = 3;
    localparam int HOLD = 9;

    logic clk    = 1'b0;
    logic reseta = 1'b0;

    door_ctrl_if bus ();

    door_ctrl #(
        .MOVE_SEC(MOVE),
        .OPEN_SEC(OPN),
        .HOLD_MAX(HOLD)
    ) dut (
        .clk   (clk),
        .reseta(reseta),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int done_seen = 0;

    // Model: phase plus ticks still to go in the current stroke / dwell / hold budget.
    int         m_phase;
    int         m_left;
    int         m_dwell;
    int         m_budget;
    int         m_travel;
    bit         m_done;
    bit         m_primed;
    logic [3:0] m_prev;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_left   = 0;
        m_dwell  = 0;
        m_budget = 0;
        m_travel = 0;
        m_done   = 0;
        m_primed = 0;
        m_prev   = 4'd0;
    endtask

    task automatic model_step();
        bit tk;
        tk       = m_primed && (bus.sec_in != m_prev);
        m_prev   = bus.sec_in;
        m_primed = 1;
        m_done   = 0;
        case (m_phase)
            0: if (bus.arrive) begin
                m_phase = 1;
                m_left  = MOVE;
            end
            1: if (tk) begin
                m_left--;
                if (m_left == 0) begin
                    m_phase  = 2;
                    m_dwell  = OPN;
                    m_budget = HOLD;
                end
            end
            2: begin
                if (tk && m_budget == 1) begin
                    m_phase  = 3;
                    m_travel = 0;
                end else if (bus.hold_btn) begin
                    m_dwell = OPN;
                    if (tk) m_budget--;
                end else if (bus.close_btn) begin
                    m_phase  = 3;
                    m_travel = 0;
                end else if (tk) begin
                    if (m_dwell == 1) begin
                        m_phase  = 3;
                        m_travel = 0;
                    end else begin
                        m_dwell--;
                        m_budget--;
                    end
                end
            end
            default: begin
                if (bus.obstruct) begin
                    m_phase = 1;
                    m_left  = (m_travel == 0) ? 1 : m_travel;
                end else if (tk) begin
                    m_travel++;
                    if (m_travel == MOVE) begin
                        m_phase = 0;
                        m_done  = 1;
                    end
                end
            end
        endcase
    endtask

    task automatic check_outputs(input string pfx);
        logic [1:0] exp_motor;
        exp_motor = (m_phase == 1) ? 2'b01 : (m_phase == 3) ? 2'b10 : 2'b00;
        chk({pfx, ".state"}, 8'(bus.state), 8'(m_phase));
        chk({pfx, ".door_open"}, 8'(bus.door_open), 8'(m_phase == 2));
        chk({pfx, ".motor"}, 8'(bus.motor), 8'(exp_motor));
        chk({pfx, ".busy"}, 8'(bus.busy), 8'(m_phase != 0));
        chk({pfx, ".done"}, 8'(bus.done), 8'(m_done));
        if (bus.done === 1'b1) done_seen++;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_outputs("cyc");
    endtask

    task automatic sec_tick();
        bus.sec_in = bus.sec_in + 4'd1;
        repeat (8) cyc();
    endtask

    task automatic pulse_arrive();
        bus.arrive = 1'b1;
        cyc();
        bus.arrive = 1'b0;
    endtask

    task automatic do_reset(input string pfx);
        reseta = 1'b0;
        #1;
        model_reset();
        check_outputs(pfx);
        @(negedge clk);
        reseta = 1'b1;
    endtask

    initial begin
        bus.sec_in    = 4'd0;
        bus.arrive    = 1'b0;
        bus.hold_btn  = 1'b0;
        bus.close_btn = 1'b0;
        bus.obstruct  = 1'b0;
        do_reset("por");

        // Plain door cycle.
        done_seen = 0;
        pulse_arrive();
        chk("a_opening", 8'(bus.state), 8'd1);
        repeat (8) sec_tick();
        chk("a_done_once", 8'(done_seen), 8'd1);
        chk("a_closed", 8'(bus.state), 8'd0);

        // Hold held throughout: forced close after HOLD ticks in OPEN.
        bus.hold_btn = 1'b1;
        pulse_arrive();
        repeat (2) sec_tick();
        chk("b_open", 8'(bus.state), 8'd2);
        repeat (HOLD - 1) sec_tick();
        chk("b_still_open", 8'(bus.state), 8'd2);
        sec_tick();
        chk("b_forced_close", 8'(bus.state), 8'd3);
        bus.hold_btn = 1'b0;
        repeat (2) sec_tick();
        chk("b_closed", 8'(bus.state), 8'd0);

        // close_btn one cycle into OPEN.
        pulse_arrive();
        sec_tick();
        bus.sec_in = bus.sec_in + 4'd1;
        cyc();
        chk("c_open", 8'(bus.state), 8'd2);
        cyc();
        bus.close_btn = 1'b1;
        cyc();
        bus.close_btn = 1'b0;
        chk("c_close", 8'(bus.state), 8'd3);
        repeat (2) sec_tick();
        chk("c_closed", 8'(bus.state), 8'd0);

        // Obstruction after one closing tick.
        pulse_arrive();
        repeat (2) sec_tick();
        bus.close_btn = 1'b1;
        cyc();
        bus.close_btn = 1'b0;
        sec_tick();
        chk("d_closing", 8'(bus.state), 8'd3);
        done_seen = 0;
        bus.obstruct = 1'b1;
        cyc();
        bus.obstruct = 1'b0;
        chk("d_reopen", 8'(bus.state), 8'd1);
        sec_tick();
        chk("d_open_after_1", 8'(bus.state), 8'd2);
        chk("d_no_done", 8'(done_seen), 8'd0);
        bus.close_btn = 1'b1;
        cyc();
        bus.close_btn = 1'b0;
        repeat (2) sec_tick();
        chk("d_closed", 8'(bus.state), 8'd0);

        // sec_in at 15 across reset release, then wrap to 0.
        bus.sec_in = 4'd15;
        do_reset("e_rst");
        bus.arrive = 1'b1;
        cyc();
        bus.arrive = 1'b0;
        chk("e_opening", 8'(bus.state), 8'd1);
        repeat (4) cyc();
        chk("e_no_phantom", 8'(bus.state), 8'd1);
        bus.sec_in = 4'd0;
        repeat (8) cyc();
        chk("e_wrap_one_tick", 8'(bus.state), 8'd1);
        sec_tick();
        chk("e_open", 8'(bus.state), 8'd2);
        repeat (5) sec_tick();
        chk("e_closed", 8'(bus.state), 8'd0);

        // Asynchronous reset mid-OPEN, then a normal cycle.
        pulse_arrive();
        repeat (3) sec_tick();
        chk("f_open", 8'(bus.state), 8'd2);
        do_reset("f_async");
        done_seen = 0;
        pulse_arrive();
        repeat (8) sec_tick();
        chk("f_done_once", 8'(done_seen), 8'd1);
        chk("f_closed", 8'(bus.state), 8'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset("rnd_rst");
            end else begin
                if ($urandom_range(0, 5) == 0) bus.sec_in = 4'($urandom);
                if ($urandom_range(0, 19) == 0) bus.hold_btn = ~bus.hold_btn;
                bus.arrive    = ($urandom_range(0, 15) == 0);
                bus.close_btn = ($urandom_range(0, 11) == 0);
                bus.obstruct  = ($urandom_range(0, 9) == 0);
                cyc();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
